controle_banco: RTL and testbench

- Initiator/sequencer for the 4-entry, 8-bit register bank. It drives the bank's sr1, sr2, dr, wrData and write inputs and consumes rdData1 and rdData2.
- Accepts one packed instruction at a time over a valid/ready handshake.
- For each instruction it reads up to two registers, computes an ALU result and writes the result back to the bank.
- Sits between the instruction source (test sequencer or future fetch unit) and the register bank.

---
 rtl/controle_banco.sv | 137 +++++++++++++
 tb/tb_controle_banco.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/controle_banco.sv
// Instruction sequencer for a 4x8 register bank: read up to two registers, run the ALU, write back.
// Optional zero/carry flags are built only when CONTROLE_FLAGS_EN is defined.
module controle_banco #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ADDR_W = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          instr_valid,
    output logic                          instr_ready,
    input  logic [2+3*ADDR_W+DATA_W-1:0]  instr,
    output logic [ADDR_W-1:0]             sr1,
    output logic [ADDR_W-1:0]             sr2,
    input  logic [DATA_W-1:0]             rdData1,
    input  logic [DATA_W-1:0]             rdData2,
    output logic [ADDR_W-1:0]             dr,
    output logic [DATA_W-1:0]             wrData,
    output logic                          write,
    output logic                          done,
    output logic [DATA_W-1:0]             result,
    output logic                          flag_z,
    output logic                          flag_c
);

    localparam int unsigned INSTR_W = 2 + 3*ADDR_W + DATA_W;
    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_LDI = 2'b11;

    typedef enum logic [1:0] {IDLE, EXEC, WB} state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic [ADDR_W-1:0]   dr_q;
    logic [DATA_W-1:0]   imm_q;
    logic [DATA_W-1:0]   alu_val;

    wire [1:0]        f_op  = instr[INSTR_W-1 -: 2];
    wire [ADDR_W-1:0] f_dr  = instr[INSTR_W-3 -: ADDR_W];
    wire [ADDR_W-1:0] f_sr1 = instr[INSTR_W-3-ADDR_W -: ADDR_W];
    wire [ADDR_W-1:0] f_sr2 = instr[DATA_W+ADDR_W-1 -: ADDR_W];
    wire [DATA_W-1:0] f_imm = instr[DATA_W-1:0];

    // ALU operates on the bank's combinational read data during EXEC
    always_comb begin
        alu_val = imm_q;
        case (op_q)
            OP_ADD:  alu_val = rdData1 + rdData2;
            OP_SUB:  alu_val = rdData1 - rdData2;
            OP_AND:  alu_val = rdData1 & rdData2;
            default: alu_val = imm_q;
        endcase
    end

`ifdef CONTROLE_FLAGS_EN
    logic alu_carry;
    logic carry_q;

    // Carry on ADD is a wrapped sum; on SUB it is an unsigned borrow
    always_comb begin
        alu_carry = 1'b0;
        case (op_q)
            OP_ADD:  alu_carry = (alu_val < rdData1);
            OP_SUB:  alu_carry = (rdData1 < rdData2);
            default: alu_carry = 1'b0;
        endcase
    end
`else
    assign flag_z = 1'b0;
    assign flag_c = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state       <= IDLE;
            instr_ready <= 1'b0;
            write       <= 1'b0;
            done        <= 1'b0;
            result      <= '0;
            sr1         <= '0;
            sr2         <= '0;
            dr          <= '0;
            wrData      <= '0;
            op_q        <= '0;
            dr_q        <= '0;
            imm_q       <= '0;
`ifdef CONTROLE_FLAGS_EN
            carry_q     <= 1'b0;
            flag_z      <= 1'b0;
            flag_c      <= 1'b0;
`endif
        end else begin
            write <= 1'b0;
            done  <= 1'b0;
            case (state)
                IDLE: begin
                    if (instr_ready && instr_valid) begin
                        op_q        <= f_op;
                        dr_q        <= f_dr;
                        imm_q       <= f_imm;
                        // LDI leaves the read ports where they were
                        if (f_op != OP_LDI) begin
                            sr1 <= f_sr1;
                            sr2 <= f_sr2;
                        end
                        instr_ready <= 1'b0;
                        state       <= EXEC;
                    end else begin
                        instr_ready <= 1'b1;
                    end
                end
                EXEC: begin
                    wrData  <= alu_val;
                    dr      <= dr_q;
`ifdef CONTROLE_FLAGS_EN
                    carry_q <= alu_carry;
`endif
                    state   <= WB;
                end
                WB: begin
                    write       <= 1'b1;
                    done        <= 1'b1;
                    result      <= wrData;
`ifdef CONTROLE_FLAGS_EN
                    flag_z      <= (wrData == '0);
                    flag_c      <= carry_q;
`endif
                    instr_ready <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_controle_banco.sv
// Scoreboard bench for controle_banco with a behavioural 4x8 register bank.
module tb_controle_banco;

`ifdef CONTROLE_FLAGS_EN
    localparam bit FLAGS = 1'b1;
`else
    localparam bit FLAGS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [15:0] instr = '0;
    logic [1:0]  sr1, sr2, dr;
    logic [7:0]  rdData1, rdData2, wrData, result;
    logic        write, done, flag_z, flag_c;

    controle_banco dut (
        .clk(clk), .reset(reset), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .sr1(sr1), .sr2(sr2), .rdData1(rdData1), .rdData2(rdData2),
        .dr(dr), .wrData(wrData), .write(write), .done(done), .result(result),
        .flag_z(flag_z), .flag_c(flag_c)
    );

    always #5 clk = ~clk;

    logic [7:0] bank [4];
    initial for (int i = 0; i < 4; i++) bank[i] = 8'd0;
    assign rdData1 = bank[sr1];
    assign rdData2 = bank[sr2];
    always @(posedge clk) if (write) bank[dr] <= wrData;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { int dr; int data; int z; int c; int cyc; } exp_t;
    exp_t q[$];
    int ref_regs [4];
    int n_vec = 0;
    int n_miss = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_miss++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every write/done pulse must match the oldest pending expectation
    always @(negedge clk) begin
        exp_t e;
        if (write || done) begin
            if (q.size() == 0) begin
                chk("unexpected_write", 1, 0);
            end else begin
                e = q.pop_front();
                chk("write", int'(write), 1);
                chk("done", int'(done), 1);
                chk("dr", int'(dr), e.dr);
                chk("wrData", int'(wrData), e.data);
                chk("result", int'(result), e.data);
                chk("latency", cyc, e.cyc);
                if (e.data >= 0) begin
                    chk("flag_z", int'(flag_z), e.z);
                    chk("flag_c", int'(flag_c), e.c);
                end
            end
        end
    end

    task automatic issue(input logic [1:0] op, input logic [1:0] d, input logic [1:0] s1,
                         input logic [1:0] s2, input logic [7:0] imm);
        int t = 0;
        int a, b, v, c;
        exp_t e;
        @(negedge clk);
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (!instr_ready) chk("ready_timeout", 0, 1);
        instr = {op, d, s1, s2, imm};
        instr_valid = 1'b1;
        a = ref_regs[s1];
        b = ref_regs[s2];
        case (op)
            2'b00: begin v = a + b; c = (v > 255) ? 1 : 0; v = v & 255; end
            2'b01: begin c = (a < b) ? 1 : 0; v = (a - b) & 255; end
            2'b10: begin v = a & b; c = 0; end
            default: begin v = int'(imm); c = 0; end
        endcase
        e.dr = int'(d); e.data = v; e.cyc = cyc + 3;
        e.z = (FLAGS && v == 0) ? 1 : 0;
        e.c = FLAGS ? c : 0;
        q.push_back(e);
        ref_regs[d] = v;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        chk("ready_low1", int'(instr_ready), 0);
        @(negedge clk);
        chk("ready_low2", int'(instr_ready), 0);
    endtask

    initial begin
        int t;
        exp_t e;
        int pat [7] = '{0, 0, 1, 0, 0, 1, 0};
        for (int i = 0; i < 4; i++) ref_regs[i] = 0;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", int'(instr_ready), 0);
        chk("rst_write", int'(write), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_flag_z", int'(flag_z), 0);
        chk("rst_flag_c", int'(flag_c), 0);
        chk("rst_sr1", int'(sr1), 0);
        chk("rst_sr2", int'(sr2), 0);
        chk("rst_dr", int'(dr), 0);
        chk("rst_wrData", int'(wrData), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("ready_after_reset", int'(instr_ready), 1);

        issue(2'b11, 2'd1, 2'd0, 2'd0, 8'd10);   // LDI r1,10
        issue(2'b11, 2'd2, 2'd0, 2'd0, 8'd20);   // LDI r2,20
        issue(2'b00, 2'd3, 2'd1, 2'd2, 8'd0);    // ADD r3 = 30
        issue(2'b01, 2'd0, 2'd1, 2'd2, 8'd0);    // SUB r0 = 246, borrow
        issue(2'b11, 2'd1, 2'd0, 2'd0, 8'd200);  // LDI r1,200
        issue(2'b00, 2'd0, 2'd1, 2'd1, 8'd0);    // ADD r0 = 144, carry
        issue(2'b11, 2'd1, 2'd0, 2'd0, 8'hF0);
        issue(2'b11, 2'd2, 2'd0, 2'd0, 8'h0F);
        issue(2'b10, 2'd0, 2'd1, 2'd2, 8'd0);    // AND r0 = 0, zero

        // Held valid with a constant LDI r2,5: three accepts, 3 cycles apart
        t = 0;
        @(negedge clk);
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk("hold_ready", int'(instr_ready), 1);
        instr = {2'b11, 2'd2, 2'd0, 2'd0, 8'd5};
        instr_valid = 1'b1;
        for (int k = 1; k <= 3; k++) begin
            e.dr = 2; e.data = 5; e.z = 0; e.c = 0; e.cyc = cyc + 3 * k;
            q.push_back(e);
        end
        ref_regs[2] = 5;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            chk("hold_ready_pattern", int'(instr_ready), pat[k]);
        end
        instr_valid = 1'b0;
        repeat (4) @(negedge clk);

        // Reset during EXEC of ADD r3,r1,r2 drops the instruction
        t = 0;
        while (!instr_ready && t < 20) begin
            @(negedge clk);
            t++;
        end
        instr = {2'b00, 2'd3, 2'd1, 2'd2, 8'd0};
        instr_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        instr_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("midrst_write", int'(write), 0);
        chk("midrst_ready", int'(instr_ready), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("midrst_ready_release", int'(instr_ready), 1);
        repeat (5) @(negedge clk);
        chk("midrst_r3_kept", int'(bank[3]), 30);

        t = 0;
        while (q.size() != 0 && t < 30) begin
            @(negedge clk);
            t++;
        end
        chk("queue_drained", q.size(), 0);
        for (int i = 0; i < 4; i++) chk("bank_final", int'(bank[i]), ref_regs[i]);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
